// File: rtl/dtw_seg_pkg.sv
// Shared types and helpers for the DTW segment sequencer.
package dtw_seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    RUN     = 2'd2,
    DISCARD = 2'd3
  } seg_state_e;

  localparam int OUT_W_DEF = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dtw_seg_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on q_o.
module dtw_seg_fifo
  import dtw_seg_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 64,
  localparam int AW     = clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_geral,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] q_o,
  output logic [CW-1:0]     usedw_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_en;
  logic              rd_en;

  // Full is judged on the pre-edge count, so a write while full is dropped
  // even if a pop happens in the same cycle.
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign usedw_o = cnt_q;
  // Storage is not reset; the head is forced to zero while nothing is buffered.
  assign q_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  // Sample storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dtw_segment_ctrl.sv
// Segment sequencer between the sample stream, zero-cross detector and DTW
// processor: buffers samples, cuts segments on zero-cross rising edges,
// pulses the processor reset and lets exactly one segment be read.
//
// state   | meaning
// IDLE    | buffering samples, waiting for an accepted boundary
// LAUNCH  | proc_rst held high for RST_CYC cycles
// RUN     | processor reads the segment through the gated port
// DISCARD | flushing the unread remainder of the segment, one per cycle
module dtw_segment_ctrl
  import dtw_seg_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  DEPTH   = 64,
  parameter int  MIN_LEN = 4,
  parameter int  RST_CYC = 2,
  parameter int  OUT_W   = OUT_W_DEF,
  localparam int UW      = clog2(DEPTH) + 1,
  localparam int RCW     = clog2(RST_CYC) + 1
) (
  input  logic                     clk,
  input  logic                     rst_geral,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     zc_flag,
  input  logic                     proc_rd,
  input  logic                     proc_done,
  output logic signed [DATA_W-1:0] proc_q,
  output logic signed [OUT_W-1:0]  seg_len,
  output logic                     proc_rst,
  output logic                     busy,
  output logic [UW-1:0]            usedw,
  output logic                     empty,
  output logic                     full,
  output logic                     overrun,
  output logic                     underrun,
  output logic [OUT_W-1:0]         seg_cnt,
  output logic [OUT_W-1:0]         miss_cnt
);

  seg_state_e        state_q;
  logic              zc_d_q;
  logic [OUT_W-1:0]  seg_len_q;
  logic [RCW-1:0]    rc_cnt_q;
  logic [OUT_W-1:0]  rd_cnt_q;
  logic [OUT_W-1:0]  rd_cnt_d;
  logic [OUT_W-1:0]  seg_cnt_q;
  logic [OUT_W-1:0]  miss_cnt_q;
  logic [OUT_W-1:0]  seg_len_d;
  logic [OUT_W-1:0]  seg_end;
  logic              overrun_q;
  logic              underrun_q;
  logic              proc_rst_q;
  logic              busy_q;

  logic [DATA_W-1:0] fifo_q;
  logic [UW-1:0]     fifo_usedw;
  logic              fifo_empty;
  logic              fifo_full;
  logic              zc_rise;
  logic              rd_room;
  logic              rd_gate;
  logic              min_ok;

  dtw_seg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_geral (rst_geral),
    .wr_i      (sample_valid),
    .data_i    (sample_in),
    .rd_i      (rd_gate),
    .q_o       (fifo_q),
    .usedw_o   (fifo_usedw),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign zc_rise   = zc_flag && !zc_d_q;
  assign seg_end   = seg_len_q + OUT_W'(1);
  assign rd_room   = (rd_cnt_q < seg_end);
  assign rd_gate   = ((state_q == RUN) && proc_rd && rd_room && !fifo_empty) ||
                     ((state_q == DISCARD) && rd_room && !fifo_empty);
  assign rd_cnt_d  = rd_gate ? (rd_cnt_q + OUT_W'(1)) : rd_cnt_q;
  assign min_ok    = (fifo_usedw >= UW'(MIN_LEN));
  // Only evaluated when min_ok holds, so usedw >= 1 and the subtraction cannot wrap.
  assign seg_len_d = OUT_W'(fifo_usedw) - OUT_W'(1);

  // Sequencer state, segment bookkeeping, counters and sticky flags.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      state_q    <= IDLE;
      zc_d_q     <= 1'b0;
      seg_len_q  <= '0;
      rc_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      seg_cnt_q  <= '0;
      miss_cnt_q <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      proc_rst_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      zc_d_q <= zc_flag;
      if (sample_valid && fifo_full) overrun_q <= 1'b1;
      if (zc_rise && (state_q != IDLE)) miss_cnt_q <= miss_cnt_q + OUT_W'(1);

      case (state_q)
        IDLE: begin
          // Short boundaries are ignored; the segment keeps growing.
          if (zc_rise && min_ok) begin
            state_q    <= LAUNCH;
            seg_len_q  <= seg_len_d;
            seg_cnt_q  <= seg_cnt_q + OUT_W'(1);
            rc_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            proc_rst_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LAUNCH: begin
          if (rc_cnt_q == RCW'(RST_CYC - 1)) begin
            state_q    <= RUN;
            proc_rst_q <= 1'b0;
          end else begin
            rc_cnt_q <= rc_cnt_q + RCW'(1);
          end
        end
        RUN: begin
          rd_cnt_q <= rd_cnt_d;
          if (proc_rd && !rd_gate) underrun_q <= 1'b1;
          // Completion counts a pop made in the same cycle as proc_done.
          if (proc_done) begin
            if (rd_cnt_d == seg_end) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DISCARD;
            end
          end
        end
        DISCARD: begin
          rd_cnt_q <= rd_cnt_d;
          if (rd_cnt_d == seg_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (fifo_empty) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            underrun_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          proc_rst_q <= 1'b0;
        end
      endcase
    end
  end

  assign proc_q   = fifo_q;
  assign seg_len  = seg_len_q;
  assign proc_rst = proc_rst_q;
  assign busy     = busy_q;
  assign usedw    = fifo_usedw;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;
  assign seg_cnt  = seg_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dtw_segment_ctrl.sv
// Bench for dtw_segment_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dtw_segment_ctrl;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 64;
  localparam int MIN_LEN = 4;
  localparam int RST_CYC = 2;
  localparam int OUT_W   = 32;
  localparam int UW      = 7;

  logic              clk = 1'b0;
  logic              rst_geral = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              zc_flag = 1'b0;
  logic              proc_rd = 1'b0;
  logic              proc_done = 1'b0;
  logic [DATA_W-1:0] proc_q;
  logic [OUT_W-1:0]  seg_len;
  logic              proc_rst;
  logic              busy;
  logic [UW-1:0]     usedw;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              underrun;
  logic [OUT_W-1:0]  seg_cnt;
  logic [OUT_W-1:0]  miss_cnt;

  dtw_segment_ctrl #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MIN_LEN (MIN_LEN),
    .RST_CYC (RST_CYC),
    .OUT_W   (OUT_W)
  ) dut (
    .clk          (clk),
    .rst_geral    (rst_geral),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .zc_flag      (zc_flag),
    .proc_rd      (proc_rd),
    .proc_done    (proc_done),
    .proc_q       (proc_q),
    .seg_len      (seg_len),
    .proc_rst     (proc_rst),
    .busy         (busy),
    .usedw        (usedw),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .underrun     (underrun),
    .seg_cnt      (seg_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode of the sequencer, samples still owed to the
  // processor in the current segment, and the FIFO contents as a queue.
  localparam int M_IDLE = 0, M_HOLD = 1, M_SERVE = 2, M_FLUSH = 3;
  logic [DATA_W-1:0] mq[$];
  int                m_mode     = M_IDLE;
  int                m_hold     = 0;
  int                m_left     = 0;
  logic [OUT_W-1:0]  m_seg_len  = '0;
  logic [OUT_W-1:0]  m_seg_cnt  = '0;
  logic [OUT_W-1:0]  m_miss_cnt = '0;
  bit                m_over     = 1'b0;
  bit                m_under    = 1'b0;
  bit                m_zc       = 1'b0;

  initial begin : model
    bit rise;
    bit pop;
    bit full_pre;
    int n;
    forever begin
      @(posedge clk or posedge rst_geral);
      if (rst_geral) begin
        mq.delete();
        m_mode = M_IDLE; m_hold = 0; m_left = 0;
        m_seg_len = '0; m_seg_cnt = '0; m_miss_cnt = '0;
        m_over = 1'b0; m_under = 1'b0; m_zc = 1'b0;
      end else begin
        n        = mq.size();
        rise     = zc_flag && !m_zc;
        full_pre = (n == DEPTH);
        pop      = 1'b0;
        if (rise && m_mode != M_IDLE) m_miss_cnt = m_miss_cnt + 1;
        case (m_mode)
          M_IDLE: if (rise && n >= MIN_LEN) begin
            m_seg_len = OUT_W'(n - 1);
            m_seg_cnt = m_seg_cnt + 1;
            m_hold    = RST_CYC;
            m_left    = n;
            m_mode    = M_HOLD;
          end
          M_HOLD: begin
            m_hold--;
            if (m_hold == 0) m_mode = M_SERVE;
          end
          M_SERVE: begin
            if (proc_rd) begin
              if (m_left > 0 && n > 0) begin pop = 1'b1; m_left--; end
              else m_under = 1'b1;
            end
            if (proc_done) m_mode = (m_left == 0) ? M_IDLE : M_FLUSH;
          end
          default: begin
            if (n == 0) begin m_under = 1'b1; m_mode = M_IDLE; end
            else begin
              pop = 1'b1; m_left--;
              if (m_left == 0) m_mode = M_IDLE;
            end
          end
        endcase
        m_zc = zc_flag;
        if (pop) void'(mq.pop_front());
        if (sample_valid) begin
          if (!full_pre) mq.push_back(sample_in);
          else m_over = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("m_usedw", usedw, mq.size());
        chk("m_empty", empty, mq.size() == 0);
        chk("m_full", full, mq.size() == DEPTH);
        chk("m_busy", busy, m_mode != M_IDLE);
        chk("m_proc_rst", proc_rst, m_mode == M_HOLD);
        chk("m_seg_len", seg_len, m_seg_len);
        chk("m_seg_cnt", seg_cnt, m_seg_cnt);
        chk("m_miss_cnt", miss_cnt, m_miss_cnt);
        chk("m_overrun", overrun, m_over);
        chk("m_underrun", underrun, m_under);
        if (mq.size() > 0) chk("m_proc_q", proc_q, mq[0]);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      sample_in    = DATA_W'(base + i);
      sample_valid = 1'b1;
      cyc();
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_zc();
    zc_flag = 1'b1;
    cyc();
    zc_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_geral = 1'b1;
    cyc();
    cyc();
    rst_geral = 1'b0;
  endtask

  task automatic wait_launch();
    for (int k = 0; k < 8; k++) begin
      if (!proc_rst) break;
      cyc();
    end
    chk("launch_end", proc_rst, 0);
  endtask

  task automatic read_n(input string name, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      proc_rd = 1'b1;
      chk(name, proc_q, DATA_W'(base + i));
      cyc();
    end
    proc_rd = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cycles);
    cycles = 0;
    while (busy && cycles < bound) begin
      cycles++;
      cyc();
    end
    chk("idle_bound", busy, 0);
  endtask

  initial begin : stim
    int n_rst;
    int n_disc;
    #1 rst_geral = 1'b1;
    cyc();
    cyc();
    mon_en = 1'b1;
    chk("rst_usedw", usedw, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_proc_q", proc_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seg_len", seg_len, 0);
    rst_geral = 1'b0;
    cyc();

    // 10-sample segment, full read, blocked 11th read.
    write_n(10, 100);
    chk("t1_usedw", usedw, 10);
    pulse_zc();
    chk("t1_seg_len", seg_len, 9);
    chk("t1_seg_cnt", seg_cnt, 1);
    chk("t1_busy", busy, 1);
    n_rst = 0;
    for (int k = 0; k < 10; k++) begin
      if (!proc_rst) break;
      n_rst++;
      cyc();
    end
    chk("t1_rst_cycles", n_rst, 2);
    read_n("t1_data", 10, 100);
    chk("t1_no_underrun", underrun, 0);
    proc_rd = 1'b1;
    cyc();
    proc_rd = 1'b0;
    chk("t1_underrun", underrun, 1);
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    chk("t1_done_idle", busy, 0);

    // Short boundary ignored, later boundary accepted.
    do_reset();
    write_n(3, 200);
    pulse_zc();
    chk("t2_short_busy", busy, 0);
    chk("t2_short_cnt", seg_cnt, 0);
    chk("t2_short_miss", miss_cnt, 0);
    write_n(2, 203);
    pulse_zc();
    chk("t2_seg_len", seg_len, 4);
    chk("t2_seg_cnt", seg_cnt, 1);

    // Early proc_done: remainder discarded, next segment surfaces.
    do_reset();
    write_n(8, 300);
    pulse_zc();
    chk("t3_seg_len", seg_len, 7);
    write_n(2, 310);
    wait_launch();
    read_n("t3_data", 3, 300);
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    chk("t3_disc_usedw0", usedw, 7);
    wait_idle(20, n_disc);
    chk("t3_disc_cycles", n_disc, 5);
    chk("t3_usedw", usedw, 2);
    chk("t3_next_head", proc_q, 310);

    // Overfill: 65 writes into 64 entries, then drain as one segment.
    do_reset();
    write_n(65, 1000);
    chk("t4_full", full, 1);
    chk("t4_usedw", usedw, 64);
    chk("t4_overrun", overrun, 1);
    pulse_zc();
    chk("t4_seg_len", seg_len, 63);
    wait_launch();
    read_n("t4_data", 64, 1000);
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_empty", empty, 1);

    // Missed boundary in RUN, simultaneous write and gated read.
    do_reset();
    write_n(6, 400);
    pulse_zc();
    wait_launch();
    pulse_zc();
    chk("t5_miss_cnt", miss_cnt, 1);
    chk("t5_busy", busy, 1);
    chk("t5_no_rst", proc_rst, 0);
    chk("t5_seg_cnt", seg_cnt, 1);
    sample_in    = 16'd410;
    sample_valid = 1'b1;
    proc_rd      = 1'b1;
    cyc();
    sample_valid = 1'b0;
    proc_rd      = 1'b0;
    chk("t5_usedw_hold", usedw, 6);
    chk("t5_head", proc_q, 401);
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
    wait_idle(20, n_disc);
    chk("t5_disc_cycles", n_disc, 5);
    chk("t5_left", usedw, 1);
    chk("t5_left_head", proc_q, 410);

    // Asynchronous reset between edges during RUN.
    do_reset();
    write_n(6, 500);
    pulse_zc();
    wait_launch();
    read_n("t6_data", 2, 500);
    @(posedge clk);
    #3 rst_geral = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_usedw", usedw, 0);
    chk("t6_empty", empty, 1);
    chk("t6_proc_q", proc_q, 0);
    chk("t6_seg_len", seg_len, 0);
    chk("t6_seg_cnt", seg_cnt, 0);
    chk("t6_proc_rst", proc_rst, 0);
    @(posedge clk);
    #2 rst_geral = 1'b0;
    cyc();
    write_n(5, 600);
    pulse_zc();
    chk("t6_new_seg_len", seg_len, 4);
    chk("t6_new_seg_cnt", seg_cnt, 1);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
